// File: rtl/sram_responder.sv
// Word-addressed SRAM responder with byte-lane writes, 1-cycle read latency,
// post-reset zero-fill sweep and sticky out-of-window access logging.
module sram_responder #(
  parameter int          ADDR_BITS      = 12,
  parameter logic [31:0] BASE_ADDR      = 32'hbfc00000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err_valid,
  output logic [31:0] err_addr,
  output logic [15:0] err_count
);
  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic {CLEAR, READY} state_t;
  state_t state;

  logic [31:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] clr_idx, idx, wr_idx;
  logic                 in_win, acc, mem_we;
  logic [3:0]           wr_be;
  logic [31:0]          wr_data;
  logic                 unused_lsb;

  assign unused_lsb = ^addr[1:0];
  assign idx    = addr[ADDR_BITS+1:2];
  assign in_win = (addr[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign acc    = en && ready;

  // One write port shared by the clear sweep and accepted in-window writes.
  always_comb begin
    mem_we  = 1'b0;
    wr_idx  = idx;
    wr_be   = wen;
    wr_data = wdata;
    if (state == CLEAR) begin
      mem_we  = 1'b1;
      wr_idx  = clr_idx;
      wr_be   = 4'hf;
      wr_data = 32'h0;
    end else if (acc && in_win && (wen != 4'h0)) begin
      mem_we = 1'b1;
    end
  end

  // No reset on the array itself; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (resetn && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= CLEAR_ON_RESET ? CLEAR : READY;
      ready     <= 1'b0;
      clr_idx   <= '0;
      rdata     <= 32'h0;
      err_valid <= 1'b0;
      err_addr  <= 32'h0;
      err_count <= 16'h0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == '1) begin
            state <= READY;
            ready <= 1'b1;
          end
        end
        default: begin
          ready <= 1'b1;
          if (acc) begin
            if (in_win) begin
              rdata <= mem[idx];  // read-first: old word even on writes
            end else begin
              rdata <= 32'h0;
              if (err_count != 16'hffff) err_count <= err_count + 16'h1;
              if (!err_valid) begin
                err_valid <= 1'b1;
                err_addr  <= addr;
              end
            end
          end
        end
      endcase
    end
  end
endmodule
